// File: rtl/fifo_uart_tx_if.sv
// Read port of the 8-bit synchronous FIFO as seen by its single consumer.
// fifo_rd_en is a one-cycle pop request, issued only when fifo_empty is low;
// fifo_data holds the popped byte from the cycle after the request.
interface fifo_uart_tx_if;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd_en;

  modport master (output fifo_rd_en, input fifo_empty, input fifo_data);
  modport slave  (input fifo_rd_en, output fifo_empty, output fifo_data);
endinterface

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the FIFO and sends each as a UART frame:
// start bit, 8 data bits LSB first, optional even parity, then 1 or 2 stop bits.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    fifo_uart_tx_if.master        fifo,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done,
    output logic [2:0]            state_dbg
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          parity;
    logic          stop_cnt;
    logic          bit_end;
    logic          last_stop;
    logic          can_start;

    assign bit_end   = (baud_cnt == CW'(CLKS_PER_BIT - 1));
    assign last_stop = (state == STOP) && bit_end && (stop_cnt == 1'(STOP_BITS - 1));
    assign can_start = enable && !fifo.fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (can_start) state_nxt = POP;
            POP:     state_nxt = LOAD;
            LOAD:    state_nxt = START;
            START:   if (bit_end) state_nxt = DATA;
            DATA:    if (bit_end && bit_idx == 3'd7)
                         state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:  if (bit_end) state_nxt = STOP;
            // Last stop cycle is the only in-frame point where a new pop is decided.
            STOP:    if (last_stop) state_nxt = can_start ? POP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            parity    <= 1'b0;
            stop_cnt  <= 1'b0;
        end else begin
            if (state inside {START, DATA, PARITY, STOP})
                baud_cnt <= bit_end ? '0 : baud_cnt + CW'(1);
            else
                baud_cnt <= '0;

            if (state == LOAD) begin
                shift_reg <= fifo.fifo_data;
                parity    <= ^fifo.fifo_data;
            end else if (state == DATA && bit_end) begin
                shift_reg <= {1'b0, shift_reg[7:1]};
            end

            if (state != DATA)
                bit_idx <= '0;
            else if (bit_end && bit_idx != 3'd7)
                bit_idx <= bit_idx + 3'd1;

            if (state != STOP)
                stop_cnt <= 1'b0;
            else if (bit_end)
                stop_cnt <= ~stop_cnt;
        end
    end

    always_comb begin
        tx = 1'b1;
        case (state)
            START:   tx = 1'b0;
            DATA:    tx = shift_reg[0];
            PARITY:  tx = parity;
            default: tx = 1'b1;
        endcase
    end

    assign fifo.fifo_rd_en = (state == POP);
    assign busy            = (state != IDLE);
    assign frame_done      = last_stop;
    assign state_dbg       = state;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: two instances (8N1 and 8E2, 4 clocks per bit)
// each fed by a small FIFO model; expected frames are built from the byte values.
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;

  logic tx_a, busy_a, done_a;
  logic tx_b, busy_b, done_b;
  logic [2:0] st_a, st_b;

  int checks = 0;
  int errors = 0;

  logic [0:0] exp_q[$];

  fifo_uart_tx_if if_a ();
  fifo_uart_tx_if if_b ();

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo(if_a),
    .tx(tx_a), .busy(busy_a), .frame_done(done_a), .state_dbg(st_a)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo(if_b),
    .tx(tx_b), .busy(busy_b), .frame_done(done_b), .state_dbg(st_b)
  );

  // clock / reset
  always #5 clk = ~clk;

  // FIFO models: read latency of one cycle
  logic [7:0] mem_a [0:15];
  logic [7:0] mem_b [0:15];
  int wp_a = 0, rp_a = 0, wp_b = 0, rp_b = 0;

  assign if_a.fifo_empty = (wp_a == rp_a);
  assign if_b.fifo_empty = (wp_b == rp_b);

  always @(posedge clk) begin
    if (if_a.fifo_rd_en) begin
      if_a.fifo_data <= mem_a[rp_a % 16];
      rp_a <= rp_a + 1;
    end
    if (if_b.fifo_rd_en) begin
      if_b.fifo_data <= mem_b[rp_b % 16];
      rp_b <= rp_b + 1;
    end
  end

  // checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic tx_of(input int sel);
    return (sel != 0) ? tx_b : tx_a;
  endfunction
  function automatic logic rd_of(input int sel);
    return (sel != 0) ? if_b.fifo_rd_en : if_a.fifo_rd_en;
  endfunction
  function automatic logic busy_of(input int sel);
    return (sel != 0) ? busy_b : busy_a;
  endfunction
  function automatic logic done_of(input int sel);
    return (sel != 0) ? done_b : done_a;
  endfunction

  // driver tasks
  task automatic push(input int sel, input logic [7:0] d);
    if (sel != 0) begin
      mem_b[wp_b % 16] = d;
      wp_b++;
    end else begin
      mem_a[wp_a % 16] = d;
      wp_a++;
    end
  endtask

  // Waits for the pop, then checks every cycle of the frame against the
  // expected bit sequence; optionally drops enable during bit position drop_pos.
  task automatic run_frame(input int sel, input logic [7:0] d, input bit par_en,
                           input int stops, input int drop_pos, output int waited);
    int n;
    bit seen;
    int nb;
    logic [0:0] bitv;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      if (rd_of(sel)) seen = 1'b1;
    end
    waited = n;
    check("pop_seen", {31'd0, seen}, 32'd1);
    @(negedge clk);
    check("pop_pulse", {31'd0, rd_of(sel)}, 32'd0);
    check("load_tx", {31'd0, tx_of(sel)}, 32'd1);
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (par_en) exp_q.push_back(^d);
    for (int i = 0; i < stops; i++) exp_q.push_back(1'b1);
    nb = exp_q.size();
    for (int b = 0; b < nb; b++) begin
      bitv = exp_q.pop_front();
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (b == drop_pos && c == 1) enable = 1'b0;
        check("tx_bit", {31'd0, tx_of(sel)}, {31'd0, bitv});
        check("frame_done", {31'd0, done_of(sel)}, {31'd0, (b == nb - 1 && c == 3)});
        check("busy_frame", {31'd0, busy_of(sel)}, 32'd1);
      end
    end
  endtask

  initial begin
    int w;
    int rd_cnt;
    int low_cnt;
    bit seen;
    int n;

    // reset state, before any clock edge
    #1;
    check("rst_tx", {31'd0, tx_a}, 32'd1);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_rd_en", {31'd0, if_a.fifo_rd_en}, 32'd0);
    check("rst_done", {31'd0, done_a}, 32'd0);
    check("rst_state", {29'd0, st_a}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // idle with empty FIFO
    enable = 1'b1;
    rd_cnt = 0;
    low_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (if_a.fifo_rd_en || if_b.fifo_rd_en) rd_cnt++;
      if (!tx_a || !tx_b || busy_a || busy_b) low_cnt++;
    end
    check("idle_no_pop", rd_cnt, 32'd0);
    check("idle_line", low_cnt, 32'd0);

    // single byte 0xA5, 8N1
    push(0, 8'hA5);
    run_frame(0, 8'hA5, 1'b0, 1, -1, w);
    @(negedge clk);
    check("single_busy_after", {31'd0, busy_a}, 32'd0);
    check("single_state_after", {29'd0, st_a}, 32'd0);

    // back-to-back 0x01, 0x02, 0x03
    enable = 1'b0;
    push(0, 8'h01);
    push(0, 8'h02);
    push(0, 8'h03);
    @(negedge clk);
    enable = 1'b1;
    run_frame(0, 8'h01, 1'b0, 1, -1, w);
    run_frame(0, 8'h02, 1'b0, 1, -1, w);
    check("b2b_gap_2", w, 32'd1);
    run_frame(0, 8'h03, 1'b0, 1, -1, w);
    check("b2b_gap_3", w, 32'd1);
    check("b2b_pops", rp_a, 32'd4);
    check("b2b_empty", {31'd0, if_a.fifo_empty}, 32'd1);
    @(negedge clk);
    check("b2b_busy_after", {31'd0, busy_a}, 32'd0);

    // even parity, two stop bits: 0x07 -> parity 1, 48-cycle frame
    push(1, 8'h07);
    run_frame(1, 8'h07, 1'b1, 2, -1, w);
    @(negedge clk);
    check("par_busy_after", {31'd0, busy_b}, 32'd0);

    // enable dropped during data bit 3 of the first of two bytes
    enable = 1'b0;
    push(0, 8'h3C);
    push(0, 8'h5A);
    @(negedge clk);
    enable = 1'b1;
    run_frame(0, 8'h3C, 1'b0, 1, 4, w);
    rd_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if_a.fifo_rd_en) rd_cnt++;
    end
    check("en_no_pop", rd_cnt, 32'd0);
    check("en_idle_busy", {31'd0, busy_a}, 32'd0);
    enable = 1'b1;
    run_frame(0, 8'h5A, 1'b0, 1, -1, w);
    check("en_resume_lat", w, 32'd1);

    // async reset during data bit 5 of 0x00
    push(0, 8'h00);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      if (if_a.fifo_rd_en) seen = 1'b1;
    end
    check("ar_pop_seen", {31'd0, seen}, 32'd1);
    repeat (27) @(negedge clk);
    check("ar_pre_state", {29'd0, st_a}, 32'd4);
    check("ar_pre_tx", {31'd0, tx_a}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_tx", {31'd0, tx_a}, 32'd1);
    check("ar_busy", {31'd0, busy_a}, 32'd0);
    check("ar_state", {29'd0, st_a}, 32'd0);
    push(0, 8'h55);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ar_rel_rd_en", {31'd0, if_a.fifo_rd_en}, 32'd0);
    check("ar_rel_busy", {31'd0, busy_a}, 32'd0);
    run_frame(0, 8'h55, 1'b0, 1, -1, w);
    check("ar_fresh_pop", w, 32'd1);
    @(negedge clk);
    check("ar_busy_after", {31'd0, busy_a}, 32'd0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
